// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one ALU operation at a time to the external
// combinational Execution unit and returns its result over a valid/ready
// response port. It also holds the architectural NZCV flag register.
// A request is accepted in IDLE, or in RESP in the same cycle its response
// is consumed. The op executes for one cycle (EXEC). The response is then
// held in RESP until rsp_ready.
// Optional feature macro: ALU_COND_EXEC_EN. When defined, the ARM condition
// field is evaluated against the flags as they were before the op. When
// undefined, every op passes and req_cond is ignored.
module alu_issue_ctrl #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 24
) (
  input  logic              clk,
  input  logic              reset,
  // request port
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_rd1,
  input  logic [DATA_W-1:0] req_rd2,
  input  logic [IMM_W-1:0]  req_imm,
  input  logic [1:0]        req_alusrc,
  input  logic              req_immsrc,
  input  logic [1:0]        req_aluctl,
  input  logic [3:0]        req_cond,
  input  logic              req_setflags,
  // registered drive to Execution
  output logic [DATA_W-1:0] exe_rd1,
  output logic [DATA_W-1:0] exe_rd2,
  output logic [IMM_W-1:0]  exe_imm,
  output logic [1:0]        exe_alusrc,
  output logic              exe_immsrc,
  output logic [1:0]        exe_aluctl,
  // results from Execution
  input  logic [3:0]        exe_aluflags,
  input  logic [DATA_W-1:0] exe_aluresult,
  // response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_exec,
  output logic [3:0]        flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] exe_rd1_q, exe_rd1_d;
  logic [DATA_W-1:0] exe_rd2_q, exe_rd2_d;
  logic [IMM_W-1:0]  exe_imm_q, exe_imm_d;
  logic [1:0]        exe_alusrc_q, exe_alusrc_d;
  logic              exe_immsrc_q, exe_immsrc_d;
  logic [1:0]        exe_aluctl_q, exe_aluctl_d;
  logic              setflags_q, setflags_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_exec_q, rsp_exec_d;
  logic [3:0]        flags_q, flags_d;

  logic accept;
  logic cond_pass;

`ifdef ALU_COND_EXEC_EN
  logic [3:0] cond_q, cond_d;
  logic       n_flag, z_flag, c_flag, v_flag;

  assign {n_flag, z_flag, c_flag, v_flag} = flags_q;

  // ARM condition decode against the flags committed before this op
  always_comb begin
    cond_pass = 1'b1;
    case (cond_q)
      4'h0: cond_pass = z_flag;
      4'h1: cond_pass = !z_flag;
      4'h2: cond_pass = c_flag;
      4'h3: cond_pass = !c_flag;
      4'h4: cond_pass = n_flag;
      4'h5: cond_pass = !n_flag;
      4'h6: cond_pass = v_flag;
      4'h7: cond_pass = !v_flag;
      4'h8: cond_pass = c_flag && !z_flag;
      4'h9: cond_pass = !c_flag || z_flag;
      4'hA: cond_pass = (n_flag == v_flag);
      4'hB: cond_pass = (n_flag != v_flag);
      4'hC: cond_pass = !z_flag && (n_flag == v_flag);
      4'hD: cond_pass = z_flag || (n_flag != v_flag);
      default: cond_pass = 1'b1;  // AL, and 0xF treated as always
    endcase
  end
`else
  // Unconditional build: every op executes and the condition field is dropped
  logic unused_cond;
  assign unused_cond = ^req_cond;
  assign cond_pass   = 1'b1;
`endif

  // Handshake outputs: ready in IDLE, or in RESP once the response is taken
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE:    req_ready = 1'b1;
      RESP: begin
        rsp_valid = 1'b1;
        req_ready = rsp_ready;
      end
      default: req_ready = 1'b0;
    endcase
  end

  assign accept = req_valid && req_ready;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_ready) state_d = req_valid ? EXEC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on accept; result/flag capture at the end of EXEC
  always_comb begin
    exe_rd1_d    = exe_rd1_q;
    exe_rd2_d    = exe_rd2_q;
    exe_imm_d    = exe_imm_q;
    exe_alusrc_d = exe_alusrc_q;
    exe_immsrc_d = exe_immsrc_q;
    exe_aluctl_d = exe_aluctl_q;
    setflags_d   = setflags_q;
`ifdef ALU_COND_EXEC_EN
    cond_d       = cond_q;
`endif
    rsp_result_d = rsp_result_q;
    rsp_exec_d   = rsp_exec_q;
    flags_d      = flags_q;

    if (accept) begin
      exe_rd1_d    = req_rd1;
      exe_rd2_d    = req_rd2;
      exe_imm_d    = req_imm;
      exe_alusrc_d = req_alusrc;
      exe_immsrc_d = req_immsrc;
      exe_aluctl_d = req_aluctl;
      setflags_d   = req_setflags;
`ifdef ALU_COND_EXEC_EN
      cond_d       = req_cond;
`endif
    end

    // accept never happens in EXEC, so these two branches never overlap
    if (state_q == EXEC) begin
      rsp_result_d = cond_pass ? exe_aluresult : '0;
      rsp_exec_d   = cond_pass;
      if (cond_pass && setflags_q) flags_d = exe_aluflags;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Operand, response and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exe_rd1_q    <= '0;
      exe_rd2_q    <= '0;
      exe_imm_q    <= '0;
      exe_alusrc_q <= '0;
      exe_immsrc_q <= 1'b0;
      exe_aluctl_q <= '0;
      setflags_q   <= 1'b0;
`ifdef ALU_COND_EXEC_EN
      cond_q       <= '0;
`endif
      rsp_result_q <= '0;
      rsp_exec_q   <= 1'b0;
      flags_q      <= '0;
    end else begin
      exe_rd1_q    <= exe_rd1_d;
      exe_rd2_q    <= exe_rd2_d;
      exe_imm_q    <= exe_imm_d;
      exe_alusrc_q <= exe_alusrc_d;
      exe_immsrc_q <= exe_immsrc_d;
      exe_aluctl_q <= exe_aluctl_d;
      setflags_q   <= setflags_d;
`ifdef ALU_COND_EXEC_EN
      cond_q       <= cond_d;
`endif
      rsp_result_q <= rsp_result_d;
      rsp_exec_q   <= rsp_exec_d;
      flags_q      <= flags_d;
    end
  end

  assign exe_rd1    = exe_rd1_q;
  assign exe_rd2    = exe_rd2_q;
  assign exe_imm    = exe_imm_q;
  assign exe_alusrc = exe_alusrc_q;
  assign exe_immsrc = exe_immsrc_q;
  assign exe_aluctl = exe_aluctl_q;
  assign rsp_result = rsp_result_q;
  assign rsp_exec   = rsp_exec_q;
  assign flags      = flags_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small stand-in for the Execution
// unit. Expectations adapt to whether ALU_COND_EXEC_EN is defined.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_rd1, req_rd2;
  logic [23:0] req_imm;
  logic [1:0]  req_alusrc;
  logic        req_immsrc;
  logic [1:0]  req_aluctl;
  logic [3:0]  req_cond;
  logic        req_setflags;
  logic [31:0] exe_rd1, exe_rd2;
  logic [23:0] exe_imm;
  logic [1:0]  exe_alusrc;
  logic        exe_immsrc;
  logic [1:0]  exe_aluctl;
  logic [3:0]  exe_aluflags;
  logic [31:0] exe_aluresult;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_exec;
  logic [3:0]  flags;

  int n_cmp = 0;
  int n_bad = 0;
  int hs_cnt = 0;

  logic [23:0] cap_imm;
  logic [1:0]  cap_alusrc;
  logic        cap_immsrc;

  alu_issue_ctrl #(.DATA_W(32), .IMM_W(24)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd1(req_rd1), .req_rd2(req_rd2), .req_imm(req_imm),
    .req_alusrc(req_alusrc), .req_immsrc(req_immsrc), .req_aluctl(req_aluctl),
    .req_cond(req_cond), .req_setflags(req_setflags),
    .exe_rd1(exe_rd1), .exe_rd2(exe_rd2), .exe_imm(exe_imm),
    .exe_alusrc(exe_alusrc), .exe_immsrc(exe_immsrc), .exe_aluctl(exe_aluctl),
    .exe_aluflags(exe_aluflags), .exe_aluresult(exe_aluresult),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_exec(rsp_exec), .flags(flags)
  );

  always #5 clk = ~clk;

  // Execution stand-in: add/sub/and/orr with NZCV
  logic [31:0] m_ext, m_srcb, m_bop, m_res;
  logic [32:0] m_sum;
  logic        m_arith;
  always_comb begin
    m_ext   = exe_immsrc ? {{8{exe_imm[23]}}, exe_imm} : {20'd0, exe_imm[11:0]};
    m_srcb  = (exe_alusrc != 2'b00) ? m_ext : exe_rd2;
    m_bop   = exe_aluctl[0] ? ~m_srcb : m_srcb;
    m_sum   = {1'b0, exe_rd1} + {1'b0, m_bop} + {32'd0, exe_aluctl[0]};
    m_arith = !exe_aluctl[1];
    case (exe_aluctl)
      2'b10:   m_res = exe_rd1 & m_srcb;
      2'b11:   m_res = exe_rd1 | m_srcb;
      default: m_res = m_sum[31:0];
    endcase
    exe_aluresult = m_res;
    exe_aluflags  = {m_res[31], (m_res == 32'd0),
                     m_arith && m_sum[32],
                     m_arith && (exe_rd1[31] == m_bop[31]) && (m_sum[31] != exe_rd1[31])};
  end

  // Count response handshakes
  always @(posedge clk) if (rsp_valid && rsp_ready) hs_cnt <= hs_cnt + 1;

  // Drive one request from IDLE, wait for its response and consume it.
  // lat = edges from accept to rsp_valid (-1 on timeout).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] ctl,
                       input logic [3:0] cond, input logic setf,
                       output int lat, output logic [31:0] res, output logic ex);
    lat = -1; res = 32'hDEAD_BEEF; ex = 1'bx;
    req_rd1 = a; req_rd2 = b; req_aluctl = ctl; req_cond = cond; req_setflags = setf;
    req_valid = 1'b1; rsp_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (req_ready) break;
      @(posedge clk); #1;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      $display("op timeout waiting for req_ready");
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    cap_imm = exe_imm; cap_alusrc = exe_alusrc; cap_immsrc = exe_immsrc;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin lat = i; break; end
    end
    res = rsp_result; ex = rsp_exec;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    $display("op a=%h b=%h ctl=%b cond=%h s=%b -> res=%h exec=%b flags=%b lat=%0d",
             a, b, ctl, cond, setf, res, ex, flags, lat);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_cmp++; if (flags !== 4'b0000) begin n_bad++; $display("FAIL reset_flags got %b want 0000", flags); end
    n_cmp++; if (rsp_result !== 32'd0 || rsp_exec !== 1'b0) begin n_bad++; $display("FAIL reset_rsp got %h/%b want 0/0", rsp_result, rsp_exec); end
    n_cmp++; if (exe_rd1 !== 32'd0 || exe_aluctl !== 2'd0 || exe_imm !== 24'd0) begin n_bad++; $display("FAIL reset_exe got %h/%b/%h want 0", exe_rd1, exe_aluctl, exe_imm); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    $display("reset done");
  endtask

  task automatic test_cond_codes;
    int lat; logic [31:0] res; logic ex;
    // flags 0000: LT (N!=V) fails when conditions are honoured
    do_op(32'd1, 32'd2, 2'b01, 4'hB, 1'b1, lat, res, ex);
`ifdef ALU_COND_EXEC_EN
    n_cmp++; if (res !== 32'd0 || ex !== 1'b0) begin n_bad++; $display("FAIL cond_lt got %h/%b want 0/0", res, ex); end
    n_cmp++; if (flags !== 4'b0000) begin n_bad++; $display("FAIL cond_lt_flags got %b want 0000", flags); end
`else
    n_cmp++; if (res !== 32'hFFFF_FFFF || ex !== 1'b1) begin n_bad++; $display("FAIL cond_lt got %h/%b want ffffffff/1", res, ex); end
    n_cmp++; if (flags !== 4'b1000) begin n_bad++; $display("FAIL cond_lt_flags got %b want 1000", flags); end
`endif
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL cond_lt_latency got %0d want 1", lat); end
    // GE passes either way (N==V or unconditional)
    do_op(32'd1, 32'd1, 2'b00, 4'hA, 1'b0, lat, res, ex);
    n_cmp++; if (res !== 32'd2 || ex !== 1'b1) begin n_bad++; $display("FAIL cond_ge got %h/%b want 2/1", res, ex); end
  endtask

  task automatic test_exe_drive;
    int lat; logic [31:0] res; logic ex;
    req_imm = 24'hABCDEF; req_alusrc = 2'b01; req_immsrc = 1'b1;
    do_op(32'd1, 32'd999, 2'b00, 4'hE, 1'b0, lat, res, ex);
    n_cmp++; if (cap_imm !== 24'hABCDEF || cap_alusrc !== 2'b01 || cap_immsrc !== 1'b1) begin n_bad++; $display("FAIL exe_drive got %h/%b/%b want abcdef/01/1", cap_imm, cap_alusrc, cap_immsrc); end
    n_cmp++; if (res !== 32'hFFAB_CDF0) begin n_bad++; $display("FAIL exe_imm_result got %h want ffabcdf0", res); end
    req_imm = 24'd0; req_alusrc = 2'b00; req_immsrc = 1'b0;
  endtask

  task automatic test_zero_flag;
    int lat; logic [31:0] res; logic ex;
    do_op(32'd444, 32'd444, 2'b01, 4'hE, 1'b1, lat, res, ex);
    n_cmp++; if (res !== 32'd0 || ex !== 1'b1) begin n_bad++; $display("FAIL zero_result got %h/%b want 0/1", res, ex); end
    n_cmp++; if (flags !== 4'b0110) begin n_bad++; $display("FAIL zero_flags got %b want 0110", flags); end
  endtask

  task automatic test_cond_fail;
    int lat; logic [31:0] res; logic ex;
    do_op(32'd5, 32'd7, 2'b00, 4'h1, 1'b1, lat, res, ex);
`ifdef ALU_COND_EXEC_EN
    n_cmp++; if (res !== 32'd0 || ex !== 1'b0) begin n_bad++; $display("FAIL ne_fail got %h/%b want 0/0", res, ex); end
    n_cmp++; if (flags !== 4'b0110) begin n_bad++; $display("FAIL ne_fail_flags got %b want 0110", flags); end
`else
    n_cmp++; if (res !== 32'd12 || ex !== 1'b1) begin n_bad++; $display("FAIL ne_uncond got %h/%b want c/1", res, ex); end
    n_cmp++; if (flags !== 4'b0000) begin n_bad++; $display("FAIL ne_uncond_flags got %b want 0000", flags); end
`endif
  endtask

  task automatic test_neg_flag;
    int lat; logic [31:0] res; logic ex;
    do_op(32'd444, 32'd44464, 2'b01, 4'hE, 1'b1, lat, res, ex);
    n_cmp++; if (res !== 32'hFFFF_540C || ex !== 1'b1) begin n_bad++; $display("FAIL neg_result got %h/%b want ffff540c/1", res, ex); end
    n_cmp++; if (flags !== 4'b1000) begin n_bad++; $display("FAIL neg_flags got %b want 1000", flags); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] vseq;
    // op A: sub 3-3, S=1
    req_rd1 = 32'd3; req_rd2 = 32'd3; req_aluctl = 2'b01; req_cond = 4'hE; req_setflags = 1'b1;
    req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;                 // A accepted
    vseq[0] = rsp_valid;
    // op B: add 10+20, EQ, S=0
    req_rd1 = 32'd10; req_rd2 = 32'd20; req_aluctl = 2'b00; req_cond = 4'h0; req_setflags = 1'b0;
    @(posedge clk); #1;                 // A response
    vseq[1] = rsp_valid;
    n_cmp++; if (rsp_result !== 32'd0 || flags !== 4'b0110) begin n_bad++; $display("FAIL b2b_first got %h/%b want 0/0110", rsp_result, flags); end
    $display("b2b A res=%h exec=%b", rsp_result, rsp_exec);
    @(posedge clk); #1;                 // A consumed, B accepted
    vseq[2] = rsp_valid;
    req_valid = 1'b0;
    @(posedge clk); #1;                 // B response
    vseq[3] = rsp_valid;
    n_cmp++; if (rsp_result !== 32'd30 || rsp_exec !== 1'b1) begin n_bad++; $display("FAIL b2b_second got %h/%b want 1e/1", rsp_result, rsp_exec); end
    n_cmp++; if (vseq !== 4'b1010) begin n_bad++; $display("FAIL b2b_valid_seq got %b want 1010", vseq); end
    $display("b2b B res=%h exec=%b", rsp_result, rsp_exec);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int hs0;
    logic stable_ok;
    // op C: orr f0|0f, held in RESP
    req_rd1 = 32'hF0; req_rd2 = 32'h0F; req_aluctl = 2'b11; req_cond = 4'hE; req_setflags = 1'b0;
    req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;                 // C accepted
    // op D: and 6&3, offered throughout
    req_rd1 = 32'd6; req_rd2 = 32'd3; req_aluctl = 2'b10;
    @(posedge clk); #1;                 // C in RESP
    stable_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_result !== 32'hFF || exe_rd1 !== 32'hF0) stable_ok = 1'b0;
      @(posedge clk); #1;
    end
    n_cmp++; if (stable_ok !== 1'b1) begin n_bad++; $display("FAIL bp_hold got rdy=%b vld=%b res=%h want 0/1/ff", req_ready, rsp_valid, rsp_result); end
    hs0 = hs_cnt;
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got %b want 1", req_ready); end
    @(posedge clk); #1;                 // C consumed, D accepted
    rsp_ready = 1'b0; req_valid = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b0 || exe_rd1 !== 32'd6) begin n_bad++; $display("FAIL bp_accept got vld=%b rd1=%h want 0/6", rsp_valid, exe_rd1); end
    @(posedge clk); #1;
    n_cmp++; if (rsp_result !== 32'd2 || rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_second got %h/%b want 2/1", rsp_result, rsp_valid); end
    n_cmp++; if (hs_cnt - hs0 !== 1) begin n_bad++; $display("FAIL bp_handshakes got %0d want 1", hs_cnt - hs0); end
    $display("backpressure C=ff D res=%h", rsp_result);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_mid_reset;
    int lat; logic [31:0] res; logic ex;
    // set some flags first so the clear is observable
    do_op(32'd0, 32'd1, 2'b01, 4'hE, 1'b1, lat, res, ex);
    req_rd1 = 32'd1; req_rd2 = 32'd1; req_aluctl = 2'b01; req_setflags = 1'b1;
    req_valid = 1'b1;
    @(posedge clk); #1;                 // accepted, now EXEC
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0 || flags !== 4'b0000) begin n_bad++; $display("FAIL midrst got vld=%b flags=%b want 0/0000", rsp_valid, flags); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_idle got vld=%b rdy=%b want 0/1", rsp_valid, req_ready); end
    do_op(32'd9, 32'd4, 2'b01, 4'hE, 1'b0, lat, res, ex);
    n_cmp++; if (res !== 32'd5 || lat !== 1) begin n_bad++; $display("FAIL midrst_next got %h lat=%0d want 5 lat=1", res, lat); end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_rd1 = '0; req_rd2 = '0; req_imm = '0; req_alusrc = '0; req_immsrc = 1'b0;
    req_aluctl = '0; req_cond = 4'hE; req_setflags = 1'b0;
    test_reset();
    test_cond_codes();
    test_exe_drive();
    test_zero_flag();
    test_cond_fail();
    test_neg_flag();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequencer that issues ALU operations to the combinational `Execution` unit and consumes its `ALUResult`/`ALUFlags` outputs. It accepts one operation at a time over a valid/ready request port and drives `Execution`'s operand and control inputs from registers. It holds the architectural NZCV flag register and evaluates the ARM condition field against it. It returns the result over a valid/ready response port, gating result and flag update on the condition outcome.

## Interface
- DATA_W, 32, operand/result width (matches `Execution`)
- IMM_W, 24, immediate field width (matches `Execution`)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid at rising clk
- req_rd1 / req_rd2  in  DATA_W  operands
- req_imm  in  IMM_W  immediate
- req_alusrc  in  2  passed to `Execution` ALUSrc
- req_immsrc  in  1  passed to `Execution` ImmSrc
- req_aluctl  in  2  00 add, 01 sub, 10 and, 11 orr
- req_cond  in  4  ARM condition code
- req_setflags  in  1  S bit: update NZCV on a passing op
- exe_rd1 / exe_rd2 / exe_imm / exe_alusrc / exe_immsrc / exe_aluctl  out  as above  registered drive to `Execution`
- exe_aluflags  in  4  {N,Z,C,V} from `Execution`
- exe_aluresult  in  DATA_W  result from `Execution`
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high with rsp_valid at rising clk
- rsp_result  out  DATA_W  result; 0 when the condition failed
- rsp_exec  out  1  condition passed
- flags  out  4  current NZCV register {N,Z,C,V}

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: req_ready=1. On req_valid, latch all req_* into the operand registers, then go to EXEC.
- EXEC: `Execution` computes combinationally from the operand registers; req_ready=0.
  - Condition is evaluated against flags *before* this op.
  - On the clock edge: capture rsp_result (exe_aluresult if pass, else 0) and rsp_exec.
  - If pass and setflags, flags <= exe_aluflags.
  - Go to RESP.
- RESP: rsp_valid=1; all rsp_* held stable until rsp_ready.
  - req_ready = rsp_ready.
  - On rsp_ready with req_valid: latch the new request and go to EXEC.
  - On rsp_ready without req_valid: go to IDLE.
  - Otherwise stay in RESP.
- Condition decode:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z
  - A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE Z|(N!=V)
  - E AL 1; F treated as pass
- A failed condition never modifies flags, even with setflags=1.
- exe_* outputs change only on a request-accept edge; they are stable throughout EXEC and RESP.

## Timing
- Reset values (asynchronous, while reset=1):
  - state IDLE, flags 4'b0000
  - rsp_valid 0, rsp_result 0, rsp_exec 0
  - all exe_* 0
  - req_ready 1 after reset deasserts
- Latency: request accepted at edge k → rsp_valid=1 after edge k+1. Flags are updated at edge k+1.
- Throughput: one op per 2 cycles when rsp_ready is held high and requests are back-to-back.
- Back-to-back dependency: the second op's condition sees flags written by the first, because the first op's flag update lands before the second op's EXEC cycle.
- Backpressure: rsp_ready low holds RESP indefinitely and blocks new requests; no request is lost or duplicated.
- Reset mid-operation (EXEC or RESP): the pending op is dropped, no response is issued, and flags clear.
- req_* changing while req_ready=0 has no effect.

## Configuration
- ALU_COND_EXEC_EN defined: condition evaluation as above.
- ALU_COND_EXEC_EN undefined:
  - req_cond is ignored and every op passes (rsp_exec=1).
  - The flag update depends only on setflags.
  - The decode logic is not synthesized.

## Test plan
- Zero flag: rd1=444, rd2=444, aluctl=01, cond=E, setflags=1 → rsp_result=0, rsp_exec=1, flags Z=1, N=0.
- Negative flag: rd1=444, rd2=44464, aluctl=01, cond=E, setflags=1 → rsp_result=32'hFFFF540C, N=1, Z=0.
- Conditional fail: after the zero-flag case, issue add 5+7 with cond=1 (NE), setflags=1 → rsp_exec=0, rsp_result=0, flags unchanged (Z=1).
- Back-to-back dependency: sub 3-3 with setflags=1, immediately followed by add 10+20 with cond=0 (EQ), rsp_ready=1 → second response has result 30, rsp_exec=1, and rsp_valid pulses on alternate cycles.
- Backpressure: hold rsp_ready=0 for 5 cycles with req_valid=1 → req_ready=0 and rsp_result stable throughout. On release, exactly one handshake occurs and the next request is accepted in the same cycle.
- Mid-op reset: assert reset during EXEC → rsp_valid=0, flags=0, state IDLE. The next request completes normally with 2-cycle latency.
